// File: rtl/spi_sclk_engine_pkg.sv
// Shared types and width helpers for the SPI serial-clock engine.
package spi_sclk_engine_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   // Width needed to hold (2^sppr_w) * 2^(2^spr_w), the largest divisor.
   function automatic int calc_div_w(input int sppr_w, input int spr_w);
      return sppr_w + (1 << spr_w) + 1;
   endfunction

endpackage

// File: rtl/spi_sclk_engine_edge_counter.sv
// Half-period counter with an SCLK toggle flop; can be frozen or cleared.
module spi_edge_counter #(
   parameter int DIV_W = 12
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             clear_i,
   input  logic             freeze_i,
   input  logic             idle_level_i,
   input  logic [DIV_W-1:0] half_period_i,
   output logic             sclk_o,
   output logic             edge_pre_o
);

   logic [DIV_W-1:0] cnt_q, cnt_d;
   logic             sclk_q, sclk_d;

   // An edge lands at the end of the cycle in which the counter reaches H-1.
   assign edge_pre_o = ~clear_i & ~freeze_i & (cnt_q == half_period_i - DIV_W'(1));
   assign sclk_o     = sclk_q;

   // Next-state: clear reloads the idle level, freeze holds, otherwise count/toggle.
   always_comb begin
      cnt_d  = cnt_q;
      sclk_d = sclk_q;
      if (clear_i) begin
         cnt_d  = '0;
         sclk_d = idle_level_i;
      end else if (!freeze_i) begin
         if (edge_pre_o) begin
            cnt_d  = '0;
            sclk_d = ~sclk_q;
         end else begin
            cnt_d = cnt_q + DIV_W'(1);
         end
      end
   end

   // Counter and SCLK state register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q  <= '0;
         sclk_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         sclk_q <= sclk_d;
      end
   end

endmodule

// File: rtl/spi_sclk_engine.sv
// SPI master serial-clock engine: baud division, edge strobes and frame control.
module spi_sclk_engine
   import spi_sclk_engine_pkg::*;
#(
   parameter  int SPPR_W = 3,
   parameter  int SPR_W  = 3,
   parameter  int LEN_W  = 5,
   localparam int DIV_W  = calc_div_w(SPPR_W, SPR_W)
) (
   input  logic              PCLK,
   input  logic              PRESETn,
   input  logic              cpol,
   input  logic              cpha,
   input  logic [SPPR_W-1:0] sppr,
   input  logic [SPR_W-1:0]  spr,
   input  logic [LEN_W-1:0]  frame_len,
   input  logic              start,
   input  logic              abort,
   input  logic              spiswai,
   output logic              sclk,
   output logic              sample_stb,
   output logic              shift_stb,
   output logic              sample_pre,
   output logic              shift_pre,
   output logic              busy,
   output logic              done,
   output logic [LEN_W-1:0]  bit_cnt,
   output logic [DIV_W-1:0]  baud_rate_divisor
);

   state_e             state_q, state_d;
   logic               cpol_q, cpol_d;
   logic               cpha_q, cpha_d;
   logic [LEN_W-1:0]   len_q, len_d;
   logic [LEN_W-1:0]   bit_cnt_q, bit_cnt_d;
   logic [DIV_W-1:0]   half_q, half_d;
   logic [LEN_W:0]     edge_q, edge_d;
   logic               sample_stb_q, sample_stb_d;
   logic               shift_stb_q, shift_stb_d;

   logic [DIV_W-1:0]   presc;
   logic [SPR_W:0]     shamt;
   logic               start_ok, cnt_clear, edge_pre, sclk_run, last_edge, is_sample;

   // Divisor (sppr+1) * 2^(spr+1), straight from the live inputs.
   assign presc             = DIV_W'(sppr) + DIV_W'(1);
   assign shamt             = {1'b0, spr} + (SPR_W+1)'(1);
   assign baud_rate_divisor = presc << shamt;

   assign start_ok  = start & ~abort & ~spiswai & (frame_len != '0);
   assign cnt_clear = (state_q != ST_RUN) | abort;
   // edge_q holds edges already completed, so an even count means a leading edge is next.
   assign last_edge = (edge_q == {len_q, 1'b0} - (LEN_W+1)'(1));
   assign is_sample = (edge_q[0] == cpha_q);

   spi_edge_counter #(.DIV_W(DIV_W)) u_edge_counter (
      .clk_i         (PCLK),
      .rst_ni        (PRESETn),
      .clear_i       (cnt_clear),
      .freeze_i      (spiswai),
      .idle_level_i  (cpol_d),
      .half_period_i (half_q),
      .sclk_o        (sclk_run),
      .edge_pre_o    (edge_pre)
   );

   assign sample_pre = edge_pre & is_sample;
   assign shift_pre  = edge_pre & ~is_sample;
   assign busy       = (state_q != ST_IDLE);
   assign done       = (state_q == ST_DONE) & ~abort;
   assign sclk       = busy ? sclk_run : cpol;
   assign sample_stb = sample_stb_q & ~abort;
   assign shift_stb  = shift_stb_q & ~abort;
   assign bit_cnt    = bit_cnt_q;

   // Frame FSM next-state, config latching, edge and bit bookkeeping.
   always_comb begin
      state_d      = state_q;
      cpol_d       = cpol_q;
      cpha_d       = cpha_q;
      len_d        = len_q;
      half_d       = half_q;
      edge_d       = edge_q;
      bit_cnt_d    = bit_cnt_q;
      sample_stb_d = sample_pre;
      shift_stb_d  = shift_pre;
      case (state_q)
         ST_IDLE: begin
            if (start_ok) begin
               state_d   = ST_RUN;
               cpol_d    = cpol;
               cpha_d    = cpha;
               len_d     = frame_len;
               half_d    = baud_rate_divisor;
               edge_d    = '0;
               bit_cnt_d = '0;
            end
         end
         ST_RUN: begin
            if (abort) begin
               state_d = ST_IDLE;
            end else if (edge_pre) begin
               edge_d = edge_q + (LEN_W+1)'(1);
               if (is_sample && (bit_cnt_q != len_q)) begin
                  bit_cnt_d = bit_cnt_q + LEN_W'(1);
               end
               if (last_edge) begin
                  state_d = ST_DONE;
               end
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // State, latched configuration and registered strobes.
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         state_q      <= ST_IDLE;
         cpol_q       <= 1'b0;
         cpha_q       <= 1'b0;
         len_q        <= '0;
         half_q       <= '0;
         edge_q       <= '0;
         bit_cnt_q    <= '0;
         sample_stb_q <= 1'b0;
         shift_stb_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         cpol_q       <= cpol_d;
         cpha_q       <= cpha_d;
         len_q        <= len_d;
         half_q       <= half_d;
         edge_q       <= edge_d;
         bit_cnt_q    <= bit_cnt_d;
         sample_stb_q <= sample_stb_d;
         shift_stb_q  <= shift_stb_d;
      end
   end

endmodule

// File: doc/spi_sclk_engine.md
SPI_SCLK_ENGINE -- requirements
Module: spi_sclk_engine

Interface
REQ-001 Parameter SPPR_W, default 3, width of prescaler select sppr.
REQ-002 Parameter SPR_W, default 3, width of exponent select spr.
REQ-003 Parameter LEN_W, default 5, width of frame_len (frame of 1..2^LEN_W-1 bits).
REQ-004 Derived constant DIV_W = SPPR_W + 2^SPR_W + 1, divisor width.
REQ-005 PCLK  in  1  sole clock; all state on rising edge.
REQ-006 PRESETn  in  1  reset, asynchronous, active-low.
REQ-007 cpol, cpha  in  1 each  SPI clock polarity / phase.
REQ-008 sppr  in  SPPR_W; spr  in  SPR_W  baud selects.
REQ-009 frame_len  in  LEN_W  bits per transfer.
REQ-010 start  in  1  request transfer; abort  in  1  cancel transfer; spiswai  in  1  wait-mode freeze.
REQ-011 sclk  out  1  SPI serial clock.
REQ-012 sample_stb, shift_stb  out  1 each  one-cycle edge strobes; sample_pre, shift_pre  out  1 each  same strobes one cycle early.
REQ-013 busy  out  1; done  out  1 (one-cycle pulse); bit_cnt  out  LEN_W  completed sample strobes.
REQ-014 baud_rate_divisor  out  DIV_W  = (sppr+1) * 2^(spr+1), combinational from live inputs.

Function
REQ-015 States IDLE, RUN, DONE; busy = (state != IDLE).
REQ-016 IDLE: sclk follows live cpol, counter = 0, no strobes.
REQ-017 IDLE -> RUN when start=1, abort=0, spiswai=0, frame_len!=0; otherwise start ignored.
REQ-018 On RUN entry, latch cpol, cpha, frame_len and divisor H; later input changes do not affect the running transfer.
REQ-019 RUN: counter increments each PCLK; when counter==H-1, counter<=0 and sclk toggles (one "edge"); half-period = H PCLK cycles, H >= 2.
REQ-020 Edges are numbered 1..2*frame_len; odd = leading, even = trailing.
REQ-021 cpha=0: sample on leading, shift on trailing; cpha=1: shift on leading, sample on trailing.
REQ-022 sample_stb/shift_stb registered, high exactly the first cycle sclk shows the new level.
REQ-023 sample_pre/shift_pre high exactly one cycle before the matching _stb.
REQ-024 bit_cnt cleared on RUN entry, incremented with each sample_stb; saturates at frame_len.
REQ-025 After edge 2*frame_len (sclk back at latched cpol): RUN -> DONE; DONE asserts done for one cycle, then -> IDLE.
REQ-026 spiswai=1 in RUN: counter, sclk, edge index frozen, all strobes low; resumes exactly where halted when spiswai=0.
REQ-027 abort=1 in RUN or DONE: next state IDLE, sclk = cpol, counter 0, no done, no strobes that cycle; abort beats spiswai and start.
REQ-028 start while busy ignored; start in DONE cycle ignored.

Reset
REQ-029 PRESETn low: state IDLE, sclk = cpol, counter 0, bit_cnt 0, all strobes, done, busy 0.
REQ-030 Reset mid-transfer abandons it immediately; no done after release.

Structure
REQ-031 Shared package holds state enum (IDLE/RUN/DONE) and DIV_W derivation function.
REQ-032 One sub-module, spi_edge_counter: half-period counter plus toggle, with freeze and clear inputs.

Verification
REQ-033 sppr=0, spr=0, frame_len=8, cpol=0, cpha=0, start -> sclk half-period 2 PCLK, 16 edges, 8 sample_stb on rising sclk, done 1 cycle, bit_cnt=8.
REQ-034 sppr=2, spr=1, cpol=1, cpha=1, frame_len=4 -> baud_rate_divisor=12, sclk idles high, shift on falling, sample on rising, each _pre one cycle before its _stb.
REQ-035 spiswai=1 for 10 cycles mid-frame -> sclk/counter hold, no strobes; total sample_stb still frame_len, done delayed exactly 10 cycles.
REQ-036 abort after 3rd edge -> next cycle IDLE, sclk=cpol, no done; new start runs full frame.
REQ-037 PRESETn pulsed low mid-RUN -> all outputs reset values asynchronously; start with frame_len=0 -> stays IDLE.
REQ-038 Change sppr/cpol during RUN -> running frame timing unchanged; new values apply on next start.
